// File: rtl/aim_match_gather.sv
// Gathers first-match positions per weight lane from the index matcher, then
// streams the hit lanes out as (lane, position) pairs, lowest lane first.
module aim_match_gather #(
  parameter int LANES  = 32,
  parameter int POS_W  = 9,
  parameter int LANE_W = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_load,
  input  logic [LANES-1:0]       i_valid,
  input  logic [LANES*POS_W-1:0] i_pos,
  input  logic                   i_finish,
  input  logic                   i_pair_ready,
  output logic                   o_pair_valid,
  output logic [LANE_W-1:0]      o_lane,
  output logic [POS_W-1:0]       o_pos,
  output logic                   o_last,
  output logic [LANE_W:0]        o_count,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_EMIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LANES-1:0]   hit_q, hit_d;
  logic [LANES-1:0]   pend_q, pend_d;
  logic [LANE_W:0]    count_q, count_d;
  logic [POS_W-1:0]   pos_q [LANES];

  logic [LANES-1:0]   capt_new;
  logic [LANES-1:0]   hit_cap;
  logic [LANE_W:0]    new_cnt;
  logic [LANES-1:0]   sel_oh;
  logic [LANE_W-1:0]  sel_lane;
  logic               accept;

  always_comb begin
    capt_new = '0;
    if (state_q == S_CAPT && i_load) capt_new = i_valid & ~hit_q;
    hit_cap = hit_q | capt_new;
    new_cnt = '0;
    for (int unsigned i = 0; i < LANES; i++) new_cnt = new_cnt + (LANE_W+1)'(capt_new[i]);
  end

  // Isolate the lowest pending bit, then encode it to a lane index.
  always_comb begin
    sel_oh   = pend_q & (~pend_q + LANES'(1));
    sel_lane = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (sel_oh[i]) sel_lane = LANE_W'(i);
    end
  end

  assign o_pair_valid = (state_q == S_EMIT) && (pend_q != '0);
  assign o_lane       = sel_lane;
  assign o_pos        = pos_q[sel_lane];
  assign o_last       = o_pair_valid && ((pend_q & (pend_q - LANES'(1))) == '0);
  assign o_count      = count_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign accept       = o_pair_valid && i_pair_ready;

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    pend_d  = pend_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_CAPT;
          hit_d   = '0;
          count_d = '0;
        end
      end
      S_CAPT: begin
        hit_d   = hit_cap;
        count_d = count_q + new_cnt;
        if (i_finish) begin
          pend_d  = hit_cap;
          state_d = (hit_cap != '0) ? S_EMIT : S_DONE;
        end
      end
      S_EMIT: begin
        if (accept) begin
          pend_d = pend_q & ~sel_oh;
          if ((pend_q & ~sel_oh) == '0) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      hit_q   <= '0;
      pend_q  <= '0;
      count_q <= '0;
      for (int unsigned k = 0; k < LANES; k++) pos_q[k] <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      for (int unsigned k = 0; k < LANES; k++) begin
        if (capt_new[k]) pos_q[k] <= i_pos[k*POS_W +: POS_W];
      end
    end
  end

endmodule

// File: tb/tb_aim_match_gather.sv
// Randomized scoreboard bench for aim_match_gather: a lane-table model predicts
// the emitted pair stream; a negedge monitor checks pairs, o_done and o_count.
module tb_aim_match_gather;

  localparam int LANES = 32;
  localparam int POS_W = 9;
  localparam int LANE_W = 5;

  logic                   clk = 0;
  logic                   rst = 1;
  logic                   start = 0;
  logic                   load = 0;
  logic [LANES-1:0]       valid = '0;
  logic [LANES*POS_W-1:0] pos = '0;
  logic                   finish = 0;
  logic                   ready = 1;
  logic                   pair_valid;
  logic [LANE_W-1:0]      lane;
  logic [POS_W-1:0]       opos;
  logic                   last;
  logic [LANE_W:0]        count;
  logic                   busy;
  logic                   done;

  aim_match_gather #(.LANES(LANES), .POS_W(POS_W), .LANE_W(LANE_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_load(load), .i_valid(valid),
    .i_pos(pos), .i_finish(finish), .i_pair_ready(ready), .o_pair_valid(pair_valid),
    .o_lane(lane), .o_pos(opos), .o_last(last), .o_count(count), .o_busy(busy),
    .o_done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int lane; int pos; bit last; } pair_t;
  pair_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int done_cnt = 0;
  int exp_cnt = 0;
  bit done_due = 0;
  int ready_mode = 0;

  bit m_hit[LANES];
  int m_pos[LANES];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [LANES*POS_W-1:0] setp(input logic [LANES*POS_W-1:0] v,
                                                   input int l, input int p);
    logic [LANES*POS_W-1:0] r;
    r = v;
    r[l*POS_W +: POS_W] = p[POS_W-1:0];
    return r;
  endfunction

  // Reference: first hit per lane wins; emission is ascending lane order.
  task automatic model_load(input logic [LANES-1:0] v, input logic [LANES*POS_W-1:0] p);
    for (int l = 0; l < LANES; l++) begin
      if (v[l] && !m_hit[l]) begin
        m_hit[l] = 1;
        m_pos[l] = int'(p[l*POS_W +: POS_W]);
      end
    end
  endtask

  task automatic model_finish;
    int n;
    int k;
    pair_t e;
    n = 0;
    for (int l = 0; l < LANES; l++) if (m_hit[l]) n++;
    exp_cnt = n;
    k = 0;
    for (int l = 0; l < LANES; l++) begin
      if (m_hit[l]) begin
        k++;
        e.lane = l; e.pos = m_pos[l]; e.last = (k == n);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic begin_run;
    for (int l = 0; l < LANES; l++) begin m_hit[l] = 0; m_pos[l] = 0; end
    start = 1;
    tick;
    start = 0;
  endtask

  task automatic do_load(input logic [LANES-1:0] v, input logic [LANES*POS_W-1:0] p,
                         input bit with_finish, input bit with_start);
    load = 1; valid = v; pos = p; finish = with_finish; start = with_start;
    model_load(v, p);
    if (with_finish) model_finish;
    tick;
    load = 0; valid = '0; finish = 0; start = 0;
    if (with_finish && exp_cnt == 0) done_due = 1;
  endtask

  task automatic do_finish;
    finish = 1;
    model_finish;
    tick;
    finish = 0;
    if (exp_cnt == 0) done_due = 1;
  endtask

  task automatic wait_done(input string name);
    int base;
    bit got;
    base = done_cnt;
    got = 0;
    for (int c = 0; c < 600; c++) begin
      if (done_cnt > base) begin got = 1; break; end
      tick;
    end
    checks++;
    if (!got || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_complete: done_seen=%0d leftover=%0d required done_seen=1 leftover=0",
               name, got, exp_q.size());
    end
  endtask

  // Ready driver runs 1ns after the stimulus so mode changes take effect in-cycle.
  initial begin
    int rc;
    rc = 0;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0: ready = 1;
        1: begin ready = (rc % 3 == 0); rc++; end
        2: ready = 1'($urandom_range(0, 1));
        default: ready = 0;
      endcase
    end
  end

  // Monitor
  initial begin
    pair_t f;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done_due) begin
          checks++;
          if (!(done && int'(count) == exp_cnt)) begin
            failures++;
            $display("FAIL done_pulse: o_done=%0d o_count=%0d required o_done=1 o_count=%0d",
                     done, count, exp_cnt);
          end
          done_due = 0;
          done_cnt++;
        end else if (done) begin
          checks++; failures++;
          $display("FAIL spurious_done: o_done=1 required 0");
        end
        if (pair_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_pair: lane=%0d pos=%0d required no pair", lane, opos);
          end else begin
            f = exp_q[0];
            if (int'(lane) != f.lane || int'(opos) != f.pos || last != f.last) begin
              failures++;
              $display("FAIL pair: lane=%0d pos=%0d last=%0d required lane=%0d pos=%0d last=%0d",
                       lane, opos, last, f.lane, f.pos, f.last);
            end
            if (ready) begin
              void'(exp_q.pop_front());
              pops++;
              if (f.last) done_due = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [LANES*POS_W-1:0] p;
    logic [LANES-1:0] v;
    int nl;
    int base;
    bit ok;

    tick; tick;
    checks++;
    if (pair_valid || busy || done || last || count != 0) begin
      failures++;
      $display("FAIL reset_state: valid=%0d busy=%0d done=%0d last=%0d count=%0d required all 0",
               pair_valid, busy, done, last, count);
    end
    rst = 0;
    tick;

    // Basic capture and emit
    begin_run;
    p = '0; p = setp(p, 3, 35); p = setp(p, 17, 50);
    do_load(32'h0002_0008, p, 0, 0);
    do_finish;
    wait_done("basic");

    // First match wins
    begin_run;
    p = '0; p = setp(p, 5, 7);
    do_load(32'h0000_0020, p, 0, 0);
    p = '0; p = setp(p, 5, 40); p = setp(p, 0, 33);
    do_load(32'h0000_0021, p, 0, 0);
    do_finish;
    wait_done("first_match");

    // No hits
    begin_run;
    do_load('0, '0, 0, 0);
    do_load('0, '0, 0, 0);
    do_finish;
    wait_done("no_hits");

    // Backpressure, all lanes
    begin_run;
    p = '0;
    for (int l = 0; l < LANES; l++) p = setp(p, l, l);
    ready_mode = 1;
    do_load('1, p, 0, 0);
    do_finish;
    wait_done("backpressure");
    ready_mode = 0;

    // Simultaneous load, finish and (ignored) start
    begin_run;
    p = '0; p = setp(p, 9, 300);
    do_load(32'h0000_0200, p, 1, 1);
    wait_done("load_finish");

    // Reset mid-emit
    begin_run;
    p = '0; p = setp(p, 1, 11); p = setp(p, 4, 44); p = setp(p, 8, 88); p = setp(p, 20, 200);
    do_load(32'h0010_0112, p, 0, 0);
    do_finish;
    base = pops;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      if (pops >= base + 2) begin ok = 1; break; end
      tick;
    end
    rst = 1;
    ready_mode = 3;
    tick;
    checks++;
    if (!ok || pair_valid || count != 0 || busy || done) begin
      failures++;
      $display("FAIL reset_mid_emit: reached=%0d valid=%0d count=%0d busy=%0d done=%0d required 1/0/0/0/0",
               ok, pair_valid, count, busy, done);
    end
    exp_q.delete();
    done_due = 0;
    rst = 0;
    ready_mode = 0;
    tick;
    begin_run;
    p = '0; p = setp(p, 30, 511); p = setp(p, 2, 1);
    do_load(32'h4000_0004, p, 0, 0);
    do_finish;
    wait_done("after_reset");

    // Randomized runs
    for (int r = 0; r < 24; r++) begin
      ready_mode = 2;
      begin_run;
      nl = $urandom_range(1, 4);
      for (int i = 0; i < nl; i++) begin
        case ($urandom_range(0, 3))
          0: v = '0;
          1: v = $urandom;
          default: v = $urandom & $urandom & $urandom;
        endcase
        p = '0;
        for (int l = 0; l < LANES; l++) p = setp(p, l, int'($urandom_range(0, 511)));
        do_load(v, p, (i == nl - 1) && r[0], 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) tick;
      end
      if (!r[0]) do_finish;
      wait_done("random");
    end
    ready_mode = 0;
    tick; tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
